// File: rtl/lsu_mem_unit.sv
// MEM-stage load/store unit: drives the dcache over multi-cycle waits,
// aligns/extends load data, and splits or faults bus-crossing accesses.
module lsu_mem_unit #(
    parameter int BUS_W          = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic [ADDR_W-1:0]     dcache_address,
    output logic                  dcache_read,
    output logic                  dcache_write,
    output logic [BUS_W-1:0]      dcache_wdata,
    output logic [BUS_W/8-1:0]    dcache_mbe,
    input  logic [BUS_W-1:0]      dcache_rdata,
    input  logic                  dcache_resp
);
    localparam int BE_W  = BUS_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam bit SPLIT = (MISALIGN_SPLIT != 0);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    state_t state, state_nx;

    logic              r_load;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_base;
    logic [OFF_W-1:0]  r_off;
    logic [3:0]        r_m4;
    logic              r_cross;
    logic              r_mis;
    logic              r_ill;
    logic [31:0]       r_wdata;
    logic [31:0]       r_acc;

    logic [OFF_W-1:0]  q_off;
    logic [3:0]        q_m4;
    logic [2:0]        q_sz;
    logic              q_legal;
    logic              q_cross;
    logic              accept;

    assign q_off  = req_addr[OFF_W-1:0];
    assign accept = req_valid && (state == IDLE);

    always_comb begin
        q_m4 = 4'b0000;
        q_sz = 3'd0;
        case (req_funct3[1:0])
            2'd0:    begin q_m4 = 4'b0001; q_sz = 3'd1; end
            2'd1:    begin q_m4 = 4'b0011; q_sz = 3'd2; end
            2'd2:    begin q_m4 = 4'b1111; q_sz = 3'd4; end
            default: begin q_m4 = 4'b0000; q_sz = 3'd0; end
        endcase
    end

    assign q_legal = req_load ? (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                              : (req_funct3 inside {3'd0, 3'd1, 3'd2});
    assign q_cross = ((OFF_W+3)'(q_off) + (OFF_W+3)'(q_sz)) > (OFF_W+3)'(BE_W);

    // Byte-lane shift amounts for the first beat and the spill-over beat
    logic [OFF_W+2:0]  sh1;
    logic [OFF_W:0]    rem;
    logic [OFF_W+3:0]  sh2;
    logic [BE_W-1:0]   mask;

    assign sh1  = {r_off, 3'b000};
    assign rem  = (OFF_W+1)'(BE_W) - {1'b0, r_off};
    assign sh2  = {rem, 3'b000};
    assign mask = BE_W'(r_m4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (accept)
                    state_nx = (!q_legal || (q_cross && !SPLIT)) ? RESP : BEAT1;
            BEAT1:
                if (dcache_resp) state_nx = r_cross ? BEAT2 : RESP;
            BEAT2:
                if (dcache_resp) state_nx = RESP;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load  <= 1'b0;
            r_f3    <= 3'd0;
            r_base  <= '0;
            r_off   <= '0;
            r_m4    <= 4'd0;
            r_cross <= 1'b0;
            r_mis   <= 1'b0;
            r_ill   <= 1'b0;
            r_wdata <= 32'd0;
            r_acc   <= 32'd0;
        end else if (accept) begin
            r_load  <= req_load;
            r_f3    <= req_funct3;
            r_base  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_off   <= q_off;
            r_m4    <= q_m4;
            r_cross <= q_cross;
            r_mis   <= q_legal && q_cross && !SPLIT;
            r_ill   <= !q_legal;
            r_wdata <= req_wdata;
            r_acc   <= 32'd0;
        end else if (dcache_resp && r_load) begin
            if (state == BEAT1)
                r_acc <= 32'(dcache_rdata >> sh1);
            else if (state == BEAT2)
                r_acc <= r_acc | (dcache_rdata[31:0] << sh2);
        end
    end

    logic [31:0] ext;

    always_comb begin
        case (r_f3)
            3'd0:    ext = {{24{r_acc[7]}}, r_acc[7:0]};
            3'd1:    ext = {{16{r_acc[15]}}, r_acc[15:0]};
            3'd4:    ext = {24'd0, r_acc[7:0]};
            3'd5:    ext = {16'd0, r_acc[15:0]};
            default: ext = r_acc;
        endcase
    end

    always_comb begin
        req_ready       = (state == IDLE);
        resp_valid      = 1'b0;
        resp_data       = 32'd0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;
        dcache_address  = '0;
        dcache_read     = 1'b0;
        dcache_write    = 1'b0;
        dcache_wdata    = '0;
        dcache_mbe      = '0;
        case (state)
            BEAT1: begin
                dcache_address = r_base;
                dcache_read    = r_load;
                dcache_write   = !r_load;
                dcache_mbe     = mask << r_off;
                dcache_wdata   = r_load ? '0 : (BUS_W'(r_wdata) << sh1);
            end
            BEAT2: begin
                dcache_address = r_base + ADDR_W'(BE_W);
                dcache_read    = r_load;
                dcache_write   = !r_load;
                dcache_mbe     = mask >> rem;
                dcache_wdata   = r_load ? '0 : (BUS_W'(r_wdata) >> sh2);
            end
            RESP: begin
                resp_valid      = 1'b1;
                resp_misaligned = r_mis;
                resp_illegal    = r_ill;
                resp_data       = (r_load && !r_mis && !r_ill) ? ext : 32'd0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit: one split-mode and one fault-mode
// instance on a 32-bit bus, driven by a small dcache responder.
module tb_lsu_mem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v1 = 1'b0;
    logic        v0 = 1'b0;
    logic        req_load = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        dresp = 1'b0;
    logic [31:0] drdata = 32'd0;

    logic        rdy_s, rv_s, mis_s, ill_s, rd_s, wr_s;
    logic [31:0] rdat_s, addr_s, wd_s;
    logic [3:0]  mbe_s;
    logic        rdy_n, rv_n, mis_n, ill_n, rd_n, wr_n;
    logic [31:0] rdat_n, addr_n, wd_n;
    logic [3:0]  mbe_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_unit #(.BUS_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_split (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy_s),
        .req_load(req_load), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_s), .resp_data(rdat_s),
        .resp_misaligned(mis_s), .resp_illegal(ill_s),
        .dcache_address(addr_s), .dcache_read(rd_s),
        .dcache_write(wr_s), .dcache_wdata(wd_s),
        .dcache_mbe(mbe_s), .dcache_rdata(drdata),
        .dcache_resp(dresp)
    );

    lsu_mem_unit #(.BUS_W(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy_n),
        .req_load(req_load), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_n), .resp_data(rdat_n),
        .resp_misaligned(mis_n), .resp_illegal(ill_n),
        .dcache_address(addr_n), .dcache_read(rd_n),
        .dcache_write(wr_n), .dcache_wdata(wd_n),
        .dcache_mbe(mbe_n), .dcache_rdata(drdata),
        .dcache_resp(dresp)
    );

    task automatic issue(input bit spl, input bit ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (spl) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v0 = 1'b0;
    endtask

    // Capture the command presented, then respond after w wait cycles
    task automatic serve(input bit spl, input int w, input logic [31:0] rd,
                         output logic [31:0] a, output logic [3:0] m,
                         output logic [31:0] wd, output logic r, output logic wr);
        a  = spl ? addr_s : addr_n;
        m  = spl ? mbe_s  : mbe_n;
        wd = spl ? wd_s   : wd_n;
        r  = spl ? rd_s   : rd_n;
        wr = spl ? wr_s   : wr_n;
        repeat (w) begin @(posedge clk); #1; end
        dresp = 1'b1; drdata = rd;
        @(posedge clk); #1;
        dresp = 1'b0; drdata = 32'd0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rdy_s !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", rdy_s); end
        n_cmp++; if ({rv_s, rd_s, wr_s, mis_s, ill_s} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {rv_s, rd_s, wr_s, mis_s, ill_s}); end
        n_cmp++; if (addr_s !== 32'd0 || mbe_s !== 4'd0) begin n_err++; $display("FAIL reset_bus got %h/%b want 0/0", addr_s, mbe_s); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        logic [31:0] a, wd; logic [3:0] m; logic r, wr;
        issue(1, 1, 3'd2, 32'h100, 32'd0);
        n_cmp++; if (rdy_s !== 1'b0) begin n_err++; $display("FAIL lw_busy got %b want 0", rdy_s); end
        serve(1, 3, 32'hDEADBEEF, a, m, wd, r, wr);
        n_cmp++; if (r !== 1'b1 || wr !== 1'b0 || a !== 32'h100) begin n_err++; $display("FAIL lw_cmd got r%b w%b %h want r1 w0 00000100", r, wr, a); end
        n_cmp++; if (rv_s !== 1'b1 || rdat_s !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_resp got %b %h want 1 deadbeef", rv_s, rdat_s); end
        @(posedge clk); #1;
        n_cmp++; if (rv_s !== 1'b0 || rdy_s !== 1'b1) begin n_err++; $display("FAIL lw_pulse got v%b r%b want v0 r1", rv_s, rdy_s); end
    endtask

    task automatic test_byte_load();
        logic [31:0] a, wd; logic [3:0] m; logic r, wr;
        issue(1, 1, 3'd0, 32'h103, 32'd0);
        serve(1, 0, 32'h80123456, a, m, wd, r, wr);
        n_cmp++; if (a !== 32'h100) begin n_err++; $display("FAIL lb_addr got %h want 00000100", a); end
        n_cmp++; if (rdat_s !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", rdat_s); end
        @(posedge clk); #1;
        issue(1, 1, 3'd4, 32'h103, 32'd0);
        serve(1, 1, 32'h80123456, a, m, wd, r, wr);
        n_cmp++; if (rdat_s !== 32'h00000080) begin n_err++; $display("FAIL lbu_data got %h want 00000080", rdat_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_half();
        logic [31:0] a, wd; logic [3:0] m; logic r, wr;
        issue(1, 0, 3'd1, 32'h102, 32'h1234ABCD);
        serve(1, 2, 32'd0, a, m, wd, r, wr);
        n_cmp++; if (wr !== 1'b1 || r !== 1'b0 || a !== 32'h100) begin n_err++; $display("FAIL sh_cmd got w%b r%b %h want w1 r0 00000100", wr, r, a); end
        n_cmp++; if (wd !== 32'hABCD0000 || m !== 4'b1100) begin n_err++; $display("FAIL sh_lane got %h %b want abcd0000 1100", wd, m); end
        n_cmp++; if (rv_s !== 1'b1 || rdat_s !== 32'd0) begin n_err++; $display("FAIL sh_single got %b %h want 1 00000000", rv_s, rdat_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_split();
        logic [31:0] a, wd; logic [3:0] m; logic r, wr;
        issue(1, 0, 3'd2, 32'h0FE, 32'hAABBCCDD);
        serve(1, 0, 32'd0, a, m, wd, r, wr);
        n_cmp++; if (a !== 32'h0FC || m !== 4'b1100 || wd !== 32'hCCDD0000) begin n_err++; $display("FAIL sw_beat1 got %h %b %h want 000000fc 1100 ccdd0000", a, m, wd); end
        n_cmp++; if (rv_s !== 1'b0) begin n_err++; $display("FAIL sw_early got %b want 0", rv_s); end
        serve(1, 1, 32'd0, a, m, wd, r, wr);
        n_cmp++; if (a !== 32'h100 || m !== 4'b0011 || wd !== 32'h0000AABB) begin n_err++; $display("FAIL sw_beat2 got %h %b %h want 00000100 0011 0000aabb", a, m, wd); end
        n_cmp++; if (rv_s !== 1'b1) begin n_err++; $display("FAIL sw_resp got %b want 1", rv_s); end
        @(posedge clk); #1;
        issue(1, 1, 3'd2, 32'h0FE, 32'd0);
        serve(1, 0, 32'h11223344, a, m, wd, r, wr);
        serve(1, 0, 32'h55667788, a, m, wd, r, wr);
        n_cmp++; if (rdat_s !== 32'h77881122) begin n_err++; $display("FAIL lw_split got %h want 77881122", rdat_s); end
        @(posedge clk); #1;
        issue(1, 1, 3'd1, 32'h103, 32'd0);
        serve(1, 0, 32'hF0000000, a, m, wd, r, wr);
        n_cmp++; if (m !== 4'b1000) begin n_err++; $display("FAIL lh_split_mbe1 got %b want 1000", m); end
        serve(1, 0, 32'h000000FF, a, m, wd, r, wr);
        n_cmp++; if (a !== 32'h104 || m !== 4'b0001) begin n_err++; $display("FAIL lh_split_beat2 got %h %b want 00000104 0001", a, m); end
        n_cmp++; if (rdat_s !== 32'hFFFFFFF0) begin n_err++; $display("FAIL lh_split_data got %h want fffffff0", rdat_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        logic [31:0] a, wd; logic [3:0] m; logic r, wr;
        issue(0, 1, 3'd2, 32'h101, 32'd0);
        n_cmp++; if (rd_n !== 1'b0 || wr_n !== 1'b0) begin n_err++; $display("FAIL mis_nocmd got r%b w%b want r0 w0", rd_n, wr_n); end
        n_cmp++; if (rv_n !== 1'b1 || mis_n !== 1'b1 || ill_n !== 1'b0 || rdat_n !== 32'd0) begin n_err++; $display("FAIL mis_resp got v%b m%b i%b %h want v1 m1 i0 0", rv_n, mis_n, ill_n, rdat_n); end
        @(posedge clk); #1;
        issue(0, 1, 3'd1, 32'h101, 32'd0);
        serve(0, 0, 32'hAABBCCDD, a, m, wd, r, wr);
        n_cmp++; if (r !== 1'b1 || a !== 32'h100 || m !== 4'b0110) begin n_err++; $display("FAIL lh_inword got r%b %h %b want r1 00000100 0110", r, a, m); end
        n_cmp++; if (mis_n !== 1'b0 || rdat_n !== 32'hFFFFBBCC) begin n_err++; $display("FAIL lh_inword_data got m%b %h want m0 ffffbbcc", mis_n, rdat_n); end
        @(posedge clk); #1;
        issue(1, 1, 3'd3, 32'h100, 32'd0);
        n_cmp++; if (rv_s !== 1'b1 || ill_s !== 1'b1 || mis_s !== 1'b0 || rd_s !== 1'b0) begin n_err++; $display("FAIL ill_load got v%b i%b m%b r%b want v1 i1 m0 r0", rv_s, ill_s, mis_s, rd_s); end
        @(posedge clk); #1;
        issue(1, 0, 3'd4, 32'h100, 32'h1);
        n_cmp++; if (rv_s !== 1'b1 || ill_s !== 1'b1 || wr_s !== 1'b0) begin n_err++; $display("FAIL ill_store got v%b i%b w%b want v1 i1 w0", rv_s, ill_s, wr_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        issue(1, 1, 3'd2, 32'h200, 32'd0);
        n_cmp++; if (rd_s !== 1'b1) begin n_err++; $display("FAIL rstmid_cmd got %b want 1", rd_s); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (rd_s !== 1'b0 || rdy_s !== 1'b1) begin n_err++; $display("FAIL rstmid_drop got r%b rdy%b want r0 rdy1", rd_s, rdy_s); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv_s === 1'b1 || rd_s === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0 || rdy_s !== 1'b1) begin n_err++; $display("FAIL rstmid_quiet got %0d events rdy%b want 0 rdy1", seen, rdy_s); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_load();
        test_store_half();
        test_split();
        test_faults();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
